// File: rtl/fir_filter_core.sv
// rtl/fir_filter_core.sv - sequential 4-tap FIR engine with one time-multiplexed multiplier
module fir_filter_core (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] sample_data,
  input  logic        data_ready,
  input  logic        new_coefficient_set,
  input  logic [15:0] fir_coefficient,
  output logic [1:0]  coefficient_num,
  output logic        modwait,
  output logic [15:0] fir_out,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD0, LOAD1, LOAD2, LOAD3,
    MAC0, MAC1, MAC2, MAC3,
    RESULT
  } state_t;

  state_t state, next_state;

  logic [15:0]        coef [4];
  logic [15:0]        taps [4];
  logic [15:0]        pend_data;
  logic               pend;
  logic signed [34:0] acc;

  logic [1:0]  mac_idx;
  logic        mac_sub;
  logic [31:0] product;
  logic        busy_latch;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (new_coefficient_set)
          next_state = LOAD0;
        else if (data_ready || pend)
          next_state = MAC0;
      end
      LOAD0:   next_state = LOAD1;
      LOAD1:   next_state = LOAD2;
      LOAD2:   next_state = LOAD3;
      LOAD3:   next_state = IDLE;
      MAC0:    next_state = MAC1;
      MAC1:    next_state = MAC2;
      MAC2:    next_state = MAC3;
      MAC3:    next_state = RESULT;
      RESULT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs depend on the state register only.
  always_comb begin
    coefficient_num = 2'd0;
    mac_idx         = 2'd0;
    case (state)
      LOAD1:   coefficient_num = 2'd1;
      LOAD2:   coefficient_num = 2'd2;
      LOAD3:   coefficient_num = 2'd3;
      MAC1:    mac_idx = 2'd1;
      MAC2:    mac_idx = 2'd2;
      MAC3:    mac_idx = 2'd3;
      default: begin
        coefficient_num = 2'd0;
        mac_idx         = 2'd0;
      end
    endcase
  end

  assign modwait    = (state != IDLE);
  assign mac_sub    = mac_idx[0];
  assign product    = {16'h0000, coef[mac_idx]} * {16'h0000, taps[mac_idx]};
  // MAC0 still sees the sample that launched it, so it must not re-capture it.
  assign busy_latch = data_ready && (state != IDLE) && (state != MAC0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      pend      <= 1'b0;
      pend_data <= 16'h0000;
      acc       <= '0;
      fir_out   <= 16'h0000;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        coef[i] <= 16'h0000;
        taps[i] <= 16'h0000;
      end
    end else begin
      state <= next_state;
      if (busy_latch) begin
        pend      <= 1'b1;
        pend_data <= sample_data;
      end
      case (state)
        IDLE: begin
          if (new_coefficient_set) begin
            if (data_ready) begin
              pend      <= 1'b1;
              pend_data <= sample_data;
            end
          end else if (data_ready || pend) begin
            taps[3] <= taps[2];
            taps[2] <= taps[1];
            taps[1] <= taps[0];
            taps[0] <= data_ready ? sample_data : pend_data;
            pend    <= 1'b0;
            acc     <= '0;
          end
        end
        LOAD0, LOAD1, LOAD2, LOAD3: coef[coefficient_num] <= fir_coefficient;
        MAC0, MAC1, MAC2, MAC3: begin
          if (mac_sub)
            acc <= acc - $signed({3'b000, product});
          else
            acc <= acc + $signed({3'b000, product});
        end
        RESULT: begin
          if (acc < 35'sd0) begin
            fir_out <= 16'h0000;
            err     <= 1'b1;
          end else if (acc > 35'sh0FFFFFFFF) begin
            fir_out <= 16'hFFFF;
            err     <= 1'b1;
          end else begin
            fir_out <= acc[31:16];
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_core.sv
// tb/tb_fir_filter_core.sv - randomized self-checking bench against an arithmetic FIR model
module tb_fir_filter_core;

  logic        clk;
  logic        n_rst;
  logic [15:0] sample_data;
  logic        data_ready;
  logic        new_coefficient_set;
  logic [15:0] fir_coefficient;
  logic [1:0]  coefficient_num;
  logic        modwait;
  logic [15:0] fir_out;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] slave_coef [4];
  longint      m_coef [4];
  longint      m_hist [4];
  logic [15:0] exp_out;
  logic        exp_err;

  fir_filter_core dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .sample_data         (sample_data),
    .data_ready          (data_ready),
    .new_coefficient_set (new_coefficient_set),
    .fir_coefficient     (fir_coefficient),
    .coefficient_num     (coefficient_num),
    .modwait             (modwait),
    .fir_out             (fir_out),
    .err                 (err)
  );

  assign fir_coefficient = slave_coef[coefficient_num];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [15:0] s);
    m_hist[3] = m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = longint'(s);
  endtask

  task automatic model_result();
    longint sum;
    sum = m_coef[0] * m_hist[0] - m_coef[1] * m_hist[1]
        + m_coef[2] * m_hist[2] - m_coef[3] * m_hist[3];
    if (sum < 0) begin
      exp_out = 16'h0000; exp_err = 1'b1;
    end else if (sum >= 64'sh1_0000_0000) begin
      exp_out = 16'hFFFF; exp_err = 1'b1;
    end else begin
      exp_out = 16'((sum / 65536) % 65536); exp_err = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_coef[i] = 0;
      m_hist[i] = 0;
    end
  endtask

  // Starts and ends on a falling edge; checks the index walk and 4-cycle busy window.
  task automatic do_load(input logic [15:0] c0, c1, c2, c3);
    slave_coef[0] = c0; slave_coef[1] = c1; slave_coef[2] = c2; slave_coef[3] = c3;
    new_coefficient_set = 1'b1;
    @(negedge clk);
    new_coefficient_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("load_cnum", 64'(coefficient_num), 64'(i));
      check_eq("load_busy", 64'(modwait), 64'd1);
      @(negedge clk);
    end
    check_eq("load_done_idle", 64'(modwait), 64'd0);
    m_coef[0] = c0; m_coef[1] = c1; m_coef[2] = c2; m_coef[3] = c3;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (modwait && cnt < 20) begin
      if (cnt != 0) check_eq("busy_cnum", 64'(coefficient_num), 64'd0);
      cnt++;
      if (cnt == 2) data_ready = 1'b0;
      @(negedge clk);
    end
    data_ready = 1'b0;
  endtask

  // data_ready stays high through MAC0, the way the slave drives it.
  task automatic do_sample(input logic [15:0] s);
    int cnt;
    sample_data = s;
    data_ready  = 1'b1;
    @(negedge clk);
    count_busy(cnt);
    check_eq("sample_busy_cycles", 64'(cnt), 64'd5);
    model_push(s);
    model_result();
    check_eq("fir_out", 64'(fir_out), 64'(exp_out));
    check_eq("err", 64'(err), 64'(exp_err));
    @(negedge clk);
    check_eq("no_double_capture", 64'(modwait), 64'd0);
  endtask

  initial begin
    int cnt;
    n_rst = 1'b0;
    sample_data = 16'h0000;
    data_ready = 1'b0;
    new_coefficient_set = 1'b0;
    for (int i = 0; i < 4; i++) slave_coef[i] = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_modwait", 64'(modwait), 64'd0);
    check_eq("rst_fir_out", 64'(fir_out), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_cnum", 64'(coefficient_num), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    do_load(16'h8000, 16'h0000, 16'h0000, 16'h0000);
    do_sample(16'h1000);
    check_eq("half_gain", 64'(fir_out), 64'h0800);

    do_load(16'h8000, 16'h8000, 16'h0000, 16'h0000);
    do_sample(16'h1000);
    do_sample(16'h2000);
    check_eq("diff_pos", 64'(fir_out), 64'h0800);
    check_eq("diff_pos_err", 64'(err), 64'd0);
    do_sample(16'h2000);
    do_sample(16'h1000);
    check_eq("diff_neg", 64'(fir_out), 64'h0000);
    check_eq("diff_neg_err", 64'(err), 64'd1);

    do_load(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000);
    do_sample(16'hFFFF);
    do_sample(16'h0000);
    do_sample(16'hFFFF);
    check_eq("overflow", 64'(fir_out), 64'hFFFF);
    check_eq("overflow_err", 64'(err), 64'd1);

    // Reload and sample in the same idle cycle: load, one idle gap, one MAC pass.
    slave_coef[0] = 16'h4000; slave_coef[1] = 16'h0000;
    slave_coef[2] = 16'h0000; slave_coef[3] = 16'h0000;
    new_coefficient_set = 1'b1;
    data_ready = 1'b1;
    sample_data = 16'h1000;
    @(negedge clk);
    new_coefficient_set = 1'b0;
    data_ready = 1'b0;
    cnt = 0;
    while (modwait && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("simul_load_cycles", 64'(cnt), 64'd4);
    check_eq("simul_gap_idle", 64'(modwait), 64'd0);
    @(negedge clk);
    count_busy(cnt);
    check_eq("simul_mac_cycles", 64'(cnt), 64'd5);
    m_coef[0] = 16'h4000; m_coef[1] = 0; m_coef[2] = 0; m_coef[3] = 0;
    model_push(16'h1000);
    model_result();
    check_eq("simul_out", 64'(fir_out), 64'(exp_out));
    check_eq("simul_out_const", 64'(fir_out), 64'h0400);
    @(negedge clk);
    check_eq("simul_no_second_pass", 64'(modwait), 64'd0);

    // Asynchronous reset in the middle of MAC2.
    sample_data = 16'h7777;
    data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check_eq("midrst_modwait", 64'(modwait), 64'd0);
    check_eq("midrst_fir_out", 64'(fir_out), 64'd0);
    check_eq("midrst_err", 64'(err), 64'd0);
    check_eq("midrst_cnum", 64'(coefficient_num), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    @(negedge clk);
    do_sample(16'h1234);
    check_eq("post_rst_zero", 64'(fir_out), 64'h0000);

    for (int r = 0; r < 8; r++) begin
      do_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      for (int k = 0; k < 3; k++) do_sample(16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
